// File: rtl/cam_capture_pkg.sv
// Shared types and constants for the OV7670 RGB565 capture block.
//   state_t : frame FSM states (S_WAIT idle/armed, S_FRAME capturing)
//   phase_t : byte-pairing phase (PH_HI expects high byte, PH_LO expects low byte)
//   X_W/Y_W : coordinate widths; H_ACTIVE_DEF/V_ACTIVE_DEF : default active window
package cam_capture_pkg;
  localparam int X_W          = 10;
  localparam int Y_W          = 9;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  typedef enum logic {S_WAIT, S_FRAME} state_t;
  typedef enum logic {PH_HI, PH_LO}    phase_t;
endpackage

// File: rtl/cam_edge_det.sv
// Registers a 1-bit input once (q) and flags edges between the registered value and
// its one-cycle-older copy.
//   clk, reset (async, active low), d : input bit
//   q : d delayed one cycle; rise/fall : single-cycle edge flags aligned with q
module cam_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic dR, dR2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dR  <= 1'b0;
      dR2 <= 1'b0;
    end else begin
      dR  <= d;
      dR2 <= dR;
    end
  end

  assign q    = dR;
  assign rise = dR & ~dR2;
  assign fall = ~dR & dR2;
endmodule

// File: rtl/camera_capture_rgb565.sv
// OV7670 parallel-bus capture: pairs bytes into RGB565 pixels tagged with X/Y and
// strobes pixelValid for one cycle per pixel inside the active window. One frame is
// captured per armed vsync falling edge.
// Ports:
//   clk, reset (async, active low)
//   capture_en : arms capture, only looked at while waiting for a frame
//   cam_vsync, cam_href, cam_data[7:0] : camera bus (high byte first)
//   pixelX[9:0], pixelY[8:0], pixel[15:0], pixelValid : pixel output
//   frame_busy, frame_done : frame status
//   line_err : sticky line-length error
// Build option: define CAM_CAPTURE_LINE_CHECK_EN to build the line-length check;
// otherwise line_err is tied low.
module camera_capture_rgb565
  import cam_capture_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           capture_en,
  input  logic           cam_vsync,
  input  logic           cam_href,
  input  logic [7:0]     cam_data,
  output logic [X_W-1:0] pixelX,
  output logic [Y_W-1:0] pixelY,
  output logic [15:0]    pixel,
  output logic           pixelValid,
  output logic           frame_busy,
  output logic           frame_done,
  output logic           line_err
);
  localparam logic [X_W-1:0] H_LIM = X_W'(H_ACTIVE);
  localparam logic [Y_W-1:0] V_LIM = Y_W'(V_ACTIVE);

  logic           vsyncR, vsRise, vsFall;
  logic           hrefR, hrFall, hrefRiseUnused;
  logic [7:0]     dataR, hiByte;
  state_t         state, stateNxt;
  phase_t         phase;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic           frameStart, frameEnd, byteEn, lineEnd;

  cam_edge_det uVsync (.clk(clk), .reset(reset), .d(cam_vsync),
                       .q(vsyncR), .rise(vsRise), .fall(vsFall));
  cam_edge_det uHref  (.clk(clk), .reset(reset), .d(cam_href),
                       .q(hrefR), .rise(hrefRiseUnused), .fall(hrFall));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dataR <= '0;
    else        dataR <= cam_data;
  end

  // Frame FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_WAIT;
    else        state <= stateNxt;
  end

  always_comb begin
    stateNxt   = state;
    frameStart = 1'b0;
    frameEnd   = 1'b0;
    if (state == S_WAIT) begin
      if (vsFall && capture_en) begin
        stateNxt   = S_FRAME;
        frameStart = 1'b1;
      end
    end else if (vsRise) begin
      stateNxt = S_WAIT;
      frameEnd = 1'b1;
    end
  end

  // The vsyncR gate covers the cycle where the rise is being detected.
  assign byteEn  = (state == S_FRAME) && hrefR && !vsyncR;
  // Still S_FRAME on a coincident vsync rise, so the line end is processed first.
  assign lineEnd = (state == S_FRAME) && hrFall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase      <= PH_HI;
      hiByte     <= '0;
      x          <= '0;
      y          <= '0;
      pixel      <= '0;
      pixelX     <= '0;
      pixelY     <= '0;
      pixelValid <= 1'b0;
      frame_busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      pixelValid <= 1'b0;
      frame_done <= 1'b0;
      if (frameStart) begin
        phase      <= PH_HI;
        x          <= '0;
        y          <= '0;
        frame_busy <= 1'b1;
      end
      if (byteEn) begin
        if (phase == PH_HI) begin
          hiByte <= dataR;
          phase  <= PH_LO;
        end else begin
          phase <= PH_HI;
          // Out-of-window pixels leave outputs untouched so they hold between strobes.
          if (x < H_LIM && y < V_LIM) begin
            pixel      <= {hiByte, dataR};
            pixelX     <= x;
            pixelY     <= y;
            pixelValid <= 1'b1;
          end
          x <= (x == '1) ? x : x + 1'b1;
        end
      end
      if (lineEnd) begin
        phase <= PH_HI;           // drops any dangling high byte
        x     <= '0;
        y     <= (y == '1) ? y : y + 1'b1;
      end
      if (frameEnd) begin
        frame_busy <= 1'b0;
        frame_done <= 1'b1;
      end
    end
  end

`ifdef CAM_CAPTURE_LINE_CHECK_EN
  logic lineErrQ;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                        lineErrQ <= 1'b0;
    else if (frameStart)                               lineErrQ <= 1'b0;
    else if (lineEnd && (x != H_LIM || phase == PH_LO)) lineErrQ <= 1'b1;
  end
  assign line_err = lineErrQ;
`else
  assign line_err = 1'b0;
`endif
endmodule

// File: tb/tb_camera_capture_rgb565.sv
module tb_camera_capture_rgb565;
  localparam int H = 4;
  localparam int V = 2;

  logic        clk = 1'b0, reset = 1'b0, capture_en = 1'b0, cam_vsync = 1'b0, cam_href = 1'b0;
  logic [7:0]  cam_data = '0;
  logic [9:0]  pixelX;
  logic [8:0]  pixelY;
  logic [15:0] pixel;
  logic        pixelValid, frame_busy, frame_done, line_err;

  camera_capture_rgb565 #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk(clk), .reset(reset), .capture_en(capture_en), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_data(cam_data), .pixelX(pixelX), .pixelY(pixelY),
    .pixel(pixel), .pixelValid(pixelValid), .frame_busy(frame_busy),
    .frame_done(frame_done), .line_err(line_err));

  always #5 clk = ~clk;

  typedef struct {bit vs; bit hr; logic [7:0] d; bit ce;} step_t;
  typedef struct {bit v; bit busy; bit done; bit err; logic [15:0] pix; logic [9:0] x; logic [8:0] y;} obs_t;
  typedef struct {int nLines; int b0; int bN; bit ce; bit ceDrop; bit coincide;
                  int expStrobes; int expDone; bit expBusy; bit expErr;} scen_t;

  step_t      stim[$];
  obs_t       act[$], expq[$];
  scen_t      tbl[8];
  int         scStart[8], scEnd[8];
  logic [7:0] fixedBytes[16];
  int         checks = 0, errors = 0;

  task automatic check(string name, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic put(bit vs, bit hr, logic [7:0] d, bit ce);
    step_t s;
    s.vs = vs; s.hr = hr; s.d = d; s.ce = ce;
    stim.push_back(s);
  endtask

  // One vsync window: 3 blanking steps, vsync fall, lines of href bytes, vsync rise.
  task automatic genFrame(int nLines, int b0, int bN, bit ce, bit ceDrop, bit coincide, bit fixedData);
    bit c;
    int nb;
    c = ce;
    for (int i = 0; i < 3; i++) put(1'b1, 1'b0, 8'h00, ce);
    for (int i = 0; i < 3; i++) put(1'b0, 1'b0, 8'h00, ce);
    for (int l = 0; l < nLines; l++) begin
      nb = (l == 0) ? b0 : bN;
      if (ceDrop && l == 1) c = 1'b0;
      for (int k = 0; k < nb; k++)
        put(1'b0, 1'b1, fixedData ? fixedBytes[l*8+k] : 8'($urandom), c);
      if (!(coincide && l == nLines - 1))
        for (int g = $urandom_range(2, 4); g > 0; g--) put(1'b0, 1'b0, 8'($urandom), c);
    end
    put(1'b1, 1'b0, 8'h00, c);
    put(1'b1, 1'b0, 8'h00, c);
  endtask

  // Reference: bytes of a captured line are collected in a list; every second byte
  // completes pixel k = n/2-1 of the current line. Sample s reflects input step s-1.
  task automatic runModel();
    obs_t       cur;
    logic [7:0] lb[$];
    bit         inF, err, pvs, phr;
    int         lineNo, k;
    cur = '{default: 0};
    inF = 0; err = 0; lineNo = 0;
    expq = {};
    expq.push_back(cur);
    for (int t = 0; t < stim.size(); t++) begin
      pvs = (t == 0) ? 1'b0 : stim[t-1].vs;
      phr = (t == 0) ? 1'b0 : stim[t-1].hr;
      cur.v = 0; cur.done = 0;
      if (!inF) begin
        if (pvs && !stim[t].vs && stim[t].ce) begin
          inF = 1; lineNo = 0; lb = {}; err = 0;
        end
      end else begin
        if (stim[t].hr && !stim[t].vs) begin
          lb.push_back(stim[t].d);
          if (lb.size() % 2 == 0) begin
            k = lb.size() / 2 - 1;
            if (k < H && lineNo < V) begin
              cur.v = 1; cur.pix = {lb[2*k], lb[2*k+1]};
              cur.x = 10'(k); cur.y = 9'(lineNo);
            end
          end
        end
        if (phr && !stim[t].hr) begin
`ifdef CAM_CAPTURE_LINE_CHECK_EN
          if (lb.size() / 2 != H || lb.size() % 2 != 0) err = 1;
`endif
          lineNo++;
          lb = {};
        end
        if (!pvs && stim[t].vs) begin
          inF = 0; cur.done = 1;
        end
      end
      cur.busy = inF; cur.err = err;
      expq.push_back(cur);
    end
  endtask

  task automatic runStream();
    obs_t o;
    act = {};
    for (int i = 0; i <= stim.size(); i++) begin
      if (i < stim.size()) begin
        cam_vsync = stim[i].vs; cam_href = stim[i].hr;
        cam_data = stim[i].d; capture_en = stim[i].ce;
      end
      @(posedge clk); @(negedge clk);
      o.v = pixelValid; o.busy = frame_busy; o.done = frame_done; o.err = line_err;
      o.pix = pixel; o.x = pixelX; o.y = pixelY;
      act.push_back(o);
    end
  endtask

  task automatic tick(bit vs, bit hr, logic [7:0] d, bit ce);
    cam_vsync = vs; cam_href = hr; cam_data = d; capture_en = ce;
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    int nStr, nDone, nBusy, first, last, rise;
    bit eErr;
    fixedBytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0,
                   8'h13, 8'h57, 8'h9B, 8'hDF, 8'h02, 8'h46, 8'h8A, 8'hCE};
    //        lines b0 bN ce drop coin  strobes done busy err
    tbl[0] = '{2,  8, 8, 1, 0, 0,  8, 1, 1, 0};  // basic 2-line frame, fixed bytes
    tbl[1] = '{2,  8, 8, 0, 0, 0,  0, 0, 0, 0};  // not armed at vsync fall
    tbl[2] = '{2,  8, 8, 1, 1, 0,  8, 1, 1, 0};  // capture_en dropped mid-frame
    tbl[3] = '{1, 12,12, 1, 0, 0,  4, 1, 1, 1};  // 6-pixel line
    tbl[4] = '{2,  8, 8, 1, 0, 0,  8, 1, 1, 0};  // error cleared at frame start
    tbl[5] = '{2,  9, 8, 1, 0, 0,  8, 1, 1, 1};  // 9-byte line, next line realigned
    tbl[6] = '{3,  8, 8, 1, 0, 0,  8, 1, 1, 0};  // extra line suppressed
    tbl[7] = '{2,  8, 8, 1, 0, 1,  8, 1, 1, 0};  // vsync rise on href fall

    // reset state
    #2;
    check("reset_outputs", {pixelValid, frame_busy, frame_done, line_err, pixel, pixelX, pixelY}, '0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      scStart[i] = stim.size();
      genFrame(tbl[i].nLines, tbl[i].b0, tbl[i].bN, tbl[i].ce, tbl[i].ceDrop, tbl[i].coincide, i == 0);
      scEnd[i] = stim.size();
    end
    for (int f = 0; f < 25; f++) begin
      int nl;
      nl = $urandom_range(1, 4);
      genFrame(nl, $urandom_range(3, 12), $urandom_range(3, 12), $urandom_range(0, 5) != 0,
               (nl > 1) && $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, 1'b0);
    end

    runModel();
    runStream();

    for (int i = 0; i < act.size(); i++) begin
      check($sformatf("ctrl[%0d]", i), {act[i].v, act[i].busy, act[i].done, act[i].err},
            {expq[i].v, expq[i].busy, expq[i].done, expq[i].err});
      check($sformatf("data[%0d]", i), {act[i].pix, act[i].x, act[i].y},
            {expq[i].pix, expq[i].x, expq[i].y});
    end

    for (int i = 0; i < 8; i++) begin
      nStr = 0; nDone = 0; nBusy = 0;
      for (int s = scStart[i] + 1; s <= scEnd[i]; s++) begin
        nStr += act[s].v; nDone += act[s].done; nBusy += act[s].busy;
      end
`ifdef CAM_CAPTURE_LINE_CHECK_EN
      eErr = tbl[i].expErr;
`else
      eErr = 1'b0;
`endif
      check($sformatf("scen%0d_strobes", i), nStr, tbl[i].expStrobes);
      check($sformatf("scen%0d_done", i), nDone, tbl[i].expDone);
      check($sformatf("scen%0d_busy", i), nBusy > 0, tbl[i].expBusy);
      check($sformatf("scen%0d_err", i), act[scEnd[i]].err, eErr);
    end

    // first frame: exact pixel values, positions and latency
    first = -1; last = -1; rise = -1;
    for (int s = scStart[0] + 1; s <= scEnd[0]; s++)
      if (act[s].v) begin
        if (first < 0) first = s;
        last = s;
      end
    for (int t = scStart[0] + 1; t < scEnd[0]; t++)
      if (!stim[t-1].vs && stim[t].vs) rise = t;
    check("first_latency", first, scStart[0] + 8);  // low byte 0x34 at step start+7
    if (first >= 0) check("first_pixel", {act[first].pix, act[first].x, act[first].y}, {16'h1234, 10'd0, 9'd0});
    if (first >= 0) check("second_pixel", {act[first+2].pix, act[first+2].x}, {16'h5678, 10'd1});
    if (last >= 0)  check("last_pixel", {act[last].pix, act[last].x, act[last].y}, {16'h8ACE, 10'd3, 9'd1});
    if (rise >= 0)  check("done_timing", {act[rise+1].done, act[rise].done}, 2'b10);

    // asynchronous reset mid-line
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 8'h00, 1'b1);
    tick(1'b0, 1'b1, 8'hA5, 1'b1);
    tick(1'b0, 1'b1, 8'h5A, 1'b1);
    tick(1'b0, 1'b1, 8'h11, 1'b1);
    check("pre_reset_pixel", {pixel, frame_busy}, {16'hA55A, 1'b1});
    reset = 1'b0;
    #1;
    check("mid_reset_outputs", {pixelValid, frame_busy, frame_done, line_err, pixel, pixelX, pixelY}, '0);
    @(negedge clk);
    reset = 1'b1;
    nStr = 0; nBusy = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b1, 8'($urandom), 1'b1);
      nStr += pixelValid; nBusy += frame_busy;
    end
    check("post_reset_strobes", nStr, 0);
    check("post_reset_busy", nBusy, 0);
    tick(1'b0, 1'b0, 8'h00, 1'b1);
    tick(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 8'h00, 1'b1);
    nStr = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b1, 8'(i + 1), 1'b1);
      nStr += pixelValid;
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 8'h00, 1'b1);
      nStr += pixelValid;
    end
    check("rearm_strobes", nStr, 4);
    check("rearm_last", {pixel, pixelX, pixelY, frame_busy}, {16'h0708, 10'd3, 9'd0, 1'b1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
